gfx_command_engine: RTL

GFX_COMMAND_ENGINE -- requirements
Module: gfx_command_engine

---
 rtl/gfx_command_engine.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/gfx_command_engine.sv
// gfx_command_engine: 4-byte command frames -> framebuffer writes
// Ports: Clk/Rst, Rx* byte sink, Tx* reply, Fb* write port, Busy, ErrorCount
module gfx_command_engine #(
  parameter int PIXEL_BITS = 3,
  parameter int ADDR_BITS = 17,
  parameter int FB_DEPTH = 120000,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter logic [7:0] ACK_BYTE = 8'h2A,
  parameter logic [7:0] NAK_BYTE = 8'h3F
) (
  input  logic Clk,
  input  logic Rst,
  input  logic [7:0] RxData,
  input  logic RxValid,
  output logic RxReady,
  output logic [7:0] TxData,
  output logic TxValid,
  input  logic TxReady,
  output logic FbWrite,
  output logic [ADDR_BITS-1:0] FbAddr,
  output logic [PIXEL_BITS-1:0] FbData,
  output logic Busy,
  output logic [15:0] ErrorCount
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] P_LAST =
    ADDR_BITS'(FB_DEPTH - 1);
  localparam logic [32:0] DEPTH33 = 33'(FB_DEPTH);

  typedef enum logic [2:0] {
    IDLE, EXEC, FILL, STREAM, RESP
  } state_t;

  state_t state, stateNext;

  logic [1:0] byteCnt;
  logic [3:0] opcode;
  logic [23:0] arg;
  logic [TW-1:0] toCnt;
  logic [ADDR_BITS-1:0] ptr;
  logic [ADDR_BITS-1:0] lastAddr;
  logic sWr;
  logic [7:0] respByte;
  logic accept;
  logic toHit;
  logic toRun;
  logic errInc;
  logic pInRange;
  logic [PIXEL_BITS-1:0] argColor;
  logic [PIXEL_BITS-1:0] rxColor;
  logic [ADDR_BITS-1:0] argAddr;
  logic argUnused;

  assign argColor = arg[ADDR_BITS+PIXEL_BITS-1:ADDR_BITS];
  assign argAddr = arg[ADDR_BITS-1:0];
  assign rxColor = RxData[7:8-PIXEL_BITS];
  assign pInRange = 33'(argAddr) < DEPTH33;
  assign argUnused = ^arg;

  assign RxReady = (state == IDLE) || (state == STREAM);
  assign accept = RxValid && RxReady;
  assign Busy = (state != IDLE);
  assign toHit = (toCnt == TO_LAST);
  assign toRun = (state == IDLE && byteCnt != 2'd0)
              || state == STREAM || state == RESP;

  // PUT and the final stream pixel reuse FILL as a
  // one-address run so the write never lands in RESP.
  assign FbWrite = (state == FILL)
                || (state == STREAM && sWr);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    errInc = 1'b0;
    respByte = NAK_BYTE;
    unique case (state)
      IDLE: begin
        if (accept && byteCnt == 2'd3)
          stateNext = EXEC;
        else if (!RxValid && byteCnt != 2'd0 && toHit)
          errInc = 1'b1;
      end
      EXEC: begin
        unique case (opcode)
          4'd1: begin
            stateNext = RESP;
            respByte = arg[7:0];
          end
          4'd2: stateNext = pInRange ? FILL : RESP;
          4'd3: stateNext = pInRange ? STREAM : RESP;
          4'd4: stateNext = FILL;
          default: begin
            stateNext = RESP;
            errInc = 1'b1;
          end
        endcase
      end
      FILL: begin
        if (FbAddr == lastAddr) begin
          stateNext = RESP;
          respByte = ACK_BYTE;
        end
      end
      STREAM: begin
        if (accept && ptr == P_LAST) begin
          stateNext = FILL;
        end else if (!RxValid && toHit) begin
          stateNext = RESP;
          errInc = 1'b1;
        end
      end
      RESP: begin
        if (TxReady) begin
          stateNext = IDLE;
        end else if (toHit) begin
          stateNext = IDLE;
          errInc = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      byteCnt <= '0;
      opcode <= '0;
      arg <= '0;
      toCnt <= '0;
      ptr <= '0;
      lastAddr <= '0;
      sWr <= 1'b0;
      FbAddr <= '0;
      FbData <= '0;
      TxData <= '0;
      TxValid <= 1'b0;
      ErrorCount <= '0;
    end else begin
      if (stateNext != state || accept || errInc)
        toCnt <= '0;
      else if (toRun)
        toCnt <= toCnt + 1'b1;

      if (errInc && ErrorCount != 16'hFFFF)
        ErrorCount <= ErrorCount + 16'd1;

      unique case (state)
        IDLE: begin
          if (accept) begin
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd0)
              opcode <= RxData[7:4];
            else
              arg <= {arg[15:0], RxData};
          end else if (errInc) begin
            byteCnt <= '0;
          end
        end
        EXEC: begin
          sWr <= 1'b0;
          ptr <= argAddr;
          FbData <= argColor;
          if (opcode == 4'd4) begin
            FbAddr <= '0;
            lastAddr <= P_LAST;
          end else begin
            FbAddr <= argAddr;
            lastAddr <= argAddr;
          end
        end
        FILL: begin
          if (FbAddr != lastAddr)
            FbAddr <= FbAddr + 1'b1;
        end
        STREAM: begin
          sWr <= accept;
          if (accept) begin
            FbAddr <= ptr;
            FbData <= rxColor;
            lastAddr <= ptr;
            ptr <= ptr + 1'b1;
          end
        end
        default: ;
      endcase

      if (stateNext == RESP && state != RESP) begin
        TxValid <= 1'b1;
        TxData <= respByte;
      end else if (state == RESP && stateNext != RESP) begin
        TxValid <= 1'b0;
      end
    end
  end

endmodule
